// File: rtl/Mem.sv
// Shared memory-access types for the pipeline memory stage and the RAM port arbiter.
package Mem;

   // Memory access kind carried by the load/store unit
   typedef enum logic [3:0] {
      NoMem     = 4'd0,
      LoadByte  = 4'd1,
      LoadHalf  = 4'd2,
      LoadWord  = 4'd3,
      ULoadByte = 4'd4,
      ULoadHalf = 4'd5,
      StoreByte = 4'd6,
      StoreHalf = 4'd7,
      StoreWord = 4'd8
   } MemType;

   // Arbiter transaction phases
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Requesting ports
   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } arb_port_t;

   function automatic logic is_store(input MemType m);
      return (m == StoreByte) || (m == StoreHalf) || (m == StoreWord);
   endfunction

   function automatic logic is_load(input MemType m);
      return (m == LoadByte) || (m == LoadHalf) || (m == LoadWord) ||
             (m == ULoadByte) || (m == ULoadHalf);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for load/store accesses: byte enables, store-data
// shift, load-field extraction with sign/zero extension, misalignment flag.
module mem_lane_align
   import Mem::*;
(
   input  MemType      memt,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [4:0]  shift;
   logic [31:0] field;

   // Lane selection and alignment check from access size and low address bits
   always_comb begin
      be         = 4'b0000;
      shift      = 5'd0;
      misaligned = 1'b0;
      case (memt)
         LoadByte, ULoadByte, StoreByte: begin
            be    = 4'b0001 << off;
            shift = {off, 3'b000};
         end
         LoadHalf, ULoadHalf, StoreHalf: begin
            be         = off[1] ? 4'b1100 : 4'b0011;
            shift      = {off[1], 4'b0000};
            misaligned = off[0];
         end
         LoadWord, StoreWord: begin
            be         = 4'b1111;
            misaligned = (off != 2'b00);
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

   assign wdata_sh = wdata << shift;
   assign field    = rdata >> shift;

   // Extend the selected load field to a full word
   always_comb begin
      rdata_ext = 32'd0;
      case (memt)
         LoadByte:  rdata_ext = {{24{field[7]}}, field[7:0]};
         ULoadByte: rdata_ext = {24'd0, field[7:0]};
         LoadHalf:  rdata_ext = {{16{field[15]}}, field[15:0]};
         ULoadHalf: rdata_ext = {16'd0, field[15:0]};
         LoadWord:  rdata_ext = field;
         default:   rdata_ext = 32'd0;
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port RAM between instruction fetch and
// load/store, with a single transaction in flight at a time.
module ram_port_arbiter
   import Mem::*;
#(
   parameter int RAM_WORDS   = 36*125*64/4,
   parameter int RAM_LATENCY = 1,
   parameter int IO_BIT      = 24
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         if_valid,
   output logic                         if_ready,
   input  logic [31:0]                  if_addr,
   output logic                         if_rsp_valid,
   output logic [31:0]                  if_rsp_data,
   input  logic                         ls_valid,
   output logic                         ls_ready,
   input  logic [31:0]                  ls_addr,
   input  MemType                       ls_memt,
   input  logic [31:0]                  ls_wdata,
   output logic                         ls_rsp_valid,
   output logic [31:0]                  ls_rsp_data,
   output logic                         ls_rsp_err,
   output logic                         ram_en,
   output logic                         ram_we,
   output logic [3:0]                   ram_be,
   output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
   output logic [31:0]                  ram_wdata,
   input  logic [31:0]                  ram_rdata
);

   localparam int AW    = $clog2(RAM_WORDS);
   localparam int CNT_W = $clog2(RAM_LATENCY + 1);

   arb_state_t       state_reg, state_next;
   arb_port_t        rr_last_reg;
   arb_port_t        owner_reg;
   logic [31:0]      addr_reg;
   MemType           memt_reg;
   logic [31:0]      wdata_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic        grant_if, grant_ls;
   logic        lane_misaligned;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        io_access;
   logic        no_ram;
   logic        unused_addr_bits;

   // Low fetch-address bits are ignored and upper latched bits only matter for the IO marker
   assign unused_addr_bits = ^{if_addr[1:0], addr_reg};

   // Both requesting: the port that did not win last time goes next
   assign grant_if = if_valid && (!ls_valid || (rr_last_reg == PORT_LS));
   assign grant_ls = ls_valid && (!if_valid || (rr_last_reg == PORT_IF));
   assign if_ready = rst && (state_reg == IDLE) && grant_if;
   assign ls_ready = rst && (state_reg == IDLE) && grant_ls;

   mem_lane_align u_align (
      .memt       (memt_reg),
      .off        (addr_reg[1:0]),
      .wdata      (wdata_reg),
      .rdata      (ram_rdata),
      .be         (lane_be),
      .wdata_sh   (lane_wdata),
      .rdata_ext  (lane_rdata),
      .misaligned (lane_misaligned)
   );

   // Accesses that never reach the RAM: IO space, misaligned, or not a load/store
   assign io_access = addr_reg[IO_BIT];
   assign no_ram    = io_access || lane_misaligned ||
                      !(is_load(memt_reg) || is_store(memt_reg));

   // Next-state and output decode for the access sequence
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_be       = 4'b0000;
      ram_addr     = '0;
      ram_wdata    = 32'd0;
      if_rsp_valid = 1'b0;
      if_rsp_data  = 32'd0;
      ls_rsp_valid = 1'b0;
      ls_rsp_data  = 32'd0;
      ls_rsp_err   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (if_ready || ls_ready) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (no_ram) begin
               state_next = RESP;
            end else begin
               ram_en    = 1'b1;
               ram_we    = is_store(memt_reg);
               ram_be    = lane_be;
               ram_addr  = addr_reg[AW+1:2];
               ram_wdata = lane_wdata;
               if (RAM_LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (cnt_reg == CNT_W'(RAM_LATENCY - 1)) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
            if (owner_reg == PORT_IF) begin
               if_rsp_valid = 1'b1;
               if_rsp_data  = no_ram ? 32'd0 : ram_rdata;
            end else begin
               ls_rsp_valid = 1'b1;
               ls_rsp_data  = (no_ram || !is_load(memt_reg)) ? 32'd0 : lane_rdata;
               ls_rsp_err   = lane_misaligned && !io_access;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Reset silences every output, including a response that would be due
      if (!rst) begin
         ram_en       = 1'b0;
         ram_we       = 1'b0;
         ram_be       = 4'b0000;
         ram_addr     = '0;
         ram_wdata    = 32'd0;
         if_rsp_valid = 1'b0;
         if_rsp_data  = 32'd0;
         ls_rsp_valid = 1'b0;
         ls_rsp_data  = 32'd0;
         ls_rsp_err   = 1'b0;
      end
   end

   // State, latency counter, round-robin pointer and request latch
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         rr_last_reg <= PORT_LS;
         owner_reg   <= PORT_IF;
         addr_reg    <= 32'd0;
         memt_reg    <= NoMem;
         wdata_reg   <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (if_ready) begin
            // Fetch is always an aligned word read
            owner_reg   <= PORT_IF;
            rr_last_reg <= PORT_IF;
            addr_reg    <= {if_addr[31:2], 2'b00};
            memt_reg    <= LoadWord;
            wdata_reg   <= 32'd0;
         end else if (ls_ready) begin
            owner_reg   <= PORT_LS;
            rr_last_reg <= PORT_LS;
            addr_reg    <= ls_addr;
            memt_reg    <= ls_memt;
            wdata_reg   <= ls_wdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at single-cycle RAM
// latency for functional checks, one at three-cycle latency for mid-access reset.
module tb_ram_port_arbiter;
   import Mem::*;

   localparam int RW = 36*125*64/4;
   localparam int AW = $clog2(RW);

   logic          clk;
   logic          rst;
   logic          if_valid, if_ready, if_rsp_valid;
   logic [31:0]   if_addr, if_rsp_data;
   logic          ls_valid, ls_ready, ls_rsp_valid, ls_rsp_err;
   logic [31:0]   ls_addr, ls_wdata, ls_rsp_data;
   MemType        ls_memt;
   logic          ram_en, ram_we;
   logic [3:0]    ram_be;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   logic          s_rst;
   logic          s_if_valid, s_if_ready, s_if_rsp_valid;
   logic [31:0]   s_if_addr, s_if_rsp_data;
   logic          s_ls_valid, s_ls_ready, s_ls_rsp_valid, s_ls_rsp_err;
   logic [31:0]   s_ls_addr, s_ls_wdata, s_ls_rsp_data;
   MemType        s_ls_memt;
   logic          s_ram_en, s_ram_we;
   logic [3:0]    s_ram_be;
   logic [AW-1:0] s_ram_addr;
   logic [31:0]   s_ram_wdata, s_ram_rdata;

   int checks   = 0;
   int failures = 0;

   int          x_en_cnt, x_en_k, x_rsp_k;
   logic        x_we, x_rsp_e;
   logic [3:0]  x_be;
   logic [31:0] x_wd, x_addr, x_rsp_d;

   ram_port_arbiter #(.RAM_WORDS(RW), .RAM_LATENCY(1), .IO_BIT(24)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
      .ls_memt(ls_memt), .ls_wdata(ls_wdata),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   ram_port_arbiter #(.RAM_WORDS(RW), .RAM_LATENCY(3), .IO_BIT(24)) dut_lat3 (
      .clk(clk), .rst(s_rst),
      .if_valid(s_if_valid), .if_ready(s_if_ready), .if_addr(s_if_addr),
      .if_rsp_valid(s_if_rsp_valid), .if_rsp_data(s_if_rsp_data),
      .ls_valid(s_ls_valid), .ls_ready(s_ls_ready), .ls_addr(s_ls_addr),
      .ls_memt(s_ls_memt), .ls_wdata(s_ls_wdata),
      .ls_rsp_valid(s_ls_rsp_valid), .ls_rsp_data(s_ls_rsp_data), .ls_rsp_err(s_ls_rsp_err),
      .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_be(s_ram_be), .ram_addr(s_ram_addr),
      .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle RAM model with byte-lane writes; preset words while in reset
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (!rst) begin
         mem[10'h040] <= 32'hDEADBEEF;
         mem[10'h080] <= 32'd0;
         mem[10'h081] <= 32'd0;
      end else if (ram_en && ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
      ram_rdata <= mem[ram_addr[9:0]];
   end

   // Three-stage read pipeline; word 0x40 holds 0xDEADBEEF
   logic [31:0] p1, p2;
   always @(posedge clk) begin
      p1          <= (s_ram_en && s_ram_addr == AW'(32'h40)) ? 32'hDEADBEEF : 32'd0;
      p2          <= p1;
      s_ram_rdata <= p2;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request on the chosen port; records RAM activity and the response
   task automatic xact(input bit is_if, input MemType mt, input logic [31:0] a,
                       input logic [31:0] wd, input string name);
      int  n;
      bit  rdy;
      @(negedge clk);
      if (is_if) begin
         if_valid = 1'b1; if_addr = a;
      end else begin
         ls_valid = 1'b1; ls_addr = a; ls_memt = mt; ls_wdata = wd;
      end
      #1;
      n   = 0;
      rdy = is_if ? if_ready : ls_ready;
      while (!rdy && n < 20) begin
         @(negedge clk); #1;
         n++;
         rdy = is_if ? if_ready : ls_ready;
      end
      if (!rdy) check_eq({name, "_ready_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      if_valid = 1'b0; ls_valid = 1'b0;
      x_en_cnt = 0; x_en_k = 0; x_rsp_k = 0;
      x_we = 1'b0; x_be = 4'd0; x_wd = 32'd0; x_addr = 32'd0; x_rsp_d = 32'd0; x_rsp_e = 1'b0;
      for (int k = 1; k <= 12 && x_rsp_k == 0; k++) begin
         @(negedge clk);
         if (ram_en) begin
            x_en_cnt++; x_en_k = k;
            x_we = ram_we; x_be = ram_be; x_wd = ram_wdata; x_addr = 32'(ram_addr);
         end
         if (is_if ? if_rsp_valid : ls_rsp_valid) begin
            x_rsp_k = k;
            x_rsp_d = is_if ? if_rsp_data : ls_rsp_data;
            x_rsp_e = is_if ? 1'b0 : ls_rsp_err;
         end
      end
      if (x_rsp_k == 0) check_eq({name, "_rsp_timeout"}, 32'd0, 32'd1);
      $display("xact %-10s addr=%08h en=%0d be=%b wd=%08h rsp@%0d data=%08h err=%b",
               name, a, x_en_cnt, x_be, x_wd, x_rsp_k, x_rsp_d, x_rsp_e);
   endtask

   initial begin
      int  g, n;
      logic seen;
      rst = 1'b0; s_rst = 1'b0;
      if_valid = 1'b1; if_addr = 32'h100;
      ls_valid = 1'b1; ls_addr = 32'd0; ls_memt = NoMem; ls_wdata = 32'd0;
      s_if_valid = 1'b0; s_if_addr = 32'd0;
      s_ls_valid = 1'b0; s_ls_addr = 32'd0; s_ls_memt = NoMem; s_ls_wdata = 32'd0;
      repeat (3) @(negedge clk);
      // Requests present during reset must not be acknowledged
      check_eq("rst_ctrl", 32'({if_ready, ls_ready, if_rsp_valid, ls_rsp_valid, ls_rsp_err,
                                ram_en, ram_we, ram_be}), 32'd0);
      check_eq("rst_data", if_rsp_data | ls_rsp_data | ram_wdata | 32'(ram_addr), 32'd0);
      if_valid = 1'b0; ls_valid = 1'b0;
      rst = 1'b1; s_rst = 1'b1;

      // Fetch from 0x100: RAM strobe one cycle after accept, data one cycle later
      xact(1'b1, LoadWord, 32'h100, 32'd0, "if_rd");
      check_eq("if_rd_en_cyc",  32'(x_en_k), 32'd1);
      check_eq("if_rd_addr",    x_addr, 32'h40);
      check_eq("if_rd_rsp_cyc", 32'(x_rsp_k), 32'd2);
      check_eq("if_rd_data",    x_rsp_d, 32'hDEADBEEF);

      // Fresh reset so the round-robin pointer starts from its reset value
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      if_valid = 1'b1; if_addr = 32'h100;
      ls_valid = 1'b1; ls_addr = 32'h104; ls_memt = LoadWord;
      g = 0; n = 0;
      while (g < 8 && n < 200) begin
         #1;
         if (if_ready && ls_ready) check_eq("rr_both_ready", 32'd1, 32'd0);
         if (if_ready || ls_ready) begin
            check_eq($sformatf("rr_grant%0d", g), {31'd0, ls_ready}, 32'(g % 2));
            $display("xact rr grant%0d port=%s", g, ls_ready ? "LS" : "IF");
            g++;
         end
         @(negedge clk);
         n++;
      end
      if_valid = 1'b0; ls_valid = 1'b0;
      if (g < 8) check_eq("rr_timeout", 32'(g), 32'd8);
      repeat (6) @(negedge clk);

      // Byte store into the top lane, then signed/unsigned byte loads
      xact(1'b0, StoreByte, 32'h203, 32'h12, "sb_12");
      check_eq("sb_12_be",  32'(x_be), 32'h8);
      check_eq("sb_12_wd",  x_wd, 32'h12000000);
      check_eq("sb_12_we",  32'(x_we), 32'd1);
      check_eq("sb_12_rsp", x_rsp_d, 32'd0);
      xact(1'b0, LoadByte, 32'h203, 32'd0, "lb_12");
      check_eq("lb_12_data", x_rsp_d, 32'h00000012);
      xact(1'b0, StoreByte, 32'h203, 32'h80, "sb_80");
      xact(1'b0, LoadByte, 32'h203, 32'd0, "lb_80");
      check_eq("lb_80_data", x_rsp_d, 32'hFFFFFF80);
      xact(1'b0, ULoadByte, 32'h203, 32'd0, "lbu_80");
      check_eq("lbu_80_data", x_rsp_d, 32'h00000080);

      // Halfword lanes
      xact(1'b0, StoreWord, 32'h204, 32'h80017F02, "sw_204");
      check_eq("sw_204_be", 32'(x_be), 32'hF);
      xact(1'b0, LoadHalf, 32'h206, 32'd0, "lh_206");
      check_eq("lh_206_data", x_rsp_d, 32'hFFFF8001);
      xact(1'b0, ULoadHalf, 32'h206, 32'd0, "lhu_206");
      check_eq("lhu_206_data", x_rsp_d, 32'h00008001);
      xact(1'b0, LoadHalf, 32'h204, 32'd0, "lh_204");
      check_eq("lh_204_data", x_rsp_d, 32'h00007F02);
      xact(1'b0, StoreHalf, 32'h206, 32'hABCD, "sh_206");
      check_eq("sh_206_be", 32'(x_be), 32'hC);
      check_eq("sh_206_wd", x_wd, 32'hABCD0000);
      xact(1'b0, LoadWord, 32'h204, 32'd0, "lw_204");
      check_eq("lw_204_data", x_rsp_d, 32'hABCD7F02);

      // Misaligned accesses report an error and leave the RAM alone
      xact(1'b0, LoadHalf, 32'h201, 32'd0, "lh_mis");
      check_eq("lh_mis_err",  32'(x_rsp_e), 32'd1);
      check_eq("lh_mis_data", x_rsp_d, 32'd0);
      check_eq("lh_mis_en",   32'(x_en_cnt), 32'd0);
      xact(1'b0, LoadWord, 32'h202, 32'd0, "lw_mis");
      check_eq("lw_mis_err",  32'(x_rsp_e), 32'd1);
      check_eq("lw_mis_en",   32'(x_en_cnt), 32'd0);
      xact(1'b0, StoreWord, 32'h205, 32'h11111111, "sw_mis");
      check_eq("sw_mis_err",  32'(x_rsp_e), 32'd1);
      check_eq("sw_mis_en",   32'(x_en_cnt), 32'd0);
      xact(1'b0, LoadWord, 32'h204, 32'd0, "lw_after");
      check_eq("lw_after_data", x_rsp_d, 32'hABCD7F02);
      check_eq("lw_after_err",  32'(x_rsp_e), 32'd0);

      // IO space, non-memory op, and an unaligned fetch address
      xact(1'b0, LoadWord, 32'h01000100, 32'd0, "ls_io");
      check_eq("ls_io_en",   32'(x_en_cnt), 32'd0);
      check_eq("ls_io_cyc",  32'(x_rsp_k), 32'd2);
      check_eq("ls_io_data", x_rsp_d, 32'd0);
      check_eq("ls_io_err",  32'(x_rsp_e), 32'd0);
      xact(1'b1, LoadWord, 32'h01000100, 32'd0, "if_io");
      check_eq("if_io_en",   32'(x_en_cnt), 32'd0);
      check_eq("if_io_data", x_rsp_d, 32'd0);
      xact(1'b0, NoMem, 32'h100, 32'd0, "ls_nop");
      check_eq("ls_nop_en",   32'(x_en_cnt), 32'd0);
      check_eq("ls_nop_data", x_rsp_d, 32'd0);
      xact(1'b1, LoadWord, 32'h102, 32'd0, "if_unal");
      check_eq("if_unal_addr", x_addr, 32'h40);
      check_eq("if_unal_data", x_rsp_d, 32'hDEADBEEF);

      // Three-cycle latency: reset while waiting drops the access
      @(negedge clk);
      s_if_valid = 1'b1; s_if_addr = 32'h100;
      #1 check_eq("l3_ready", 32'(s_if_ready), 32'd1);
      @(posedge clk); #1 s_if_valid = 1'b0;
      @(negedge clk);
      check_eq("l3_issue_en", 32'(s_ram_en), 32'd1);
      @(negedge clk);
      s_rst = 1'b0;
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen = seen | s_if_rsp_valid | s_ls_rsp_valid | s_ram_en;
      end
      check_eq("l3_rst_outs", 32'({s_if_ready, s_ls_ready, s_if_rsp_valid, s_ls_rsp_valid,
                                   s_ls_rsp_err, s_ram_en, s_ram_we, s_ram_be}), 32'd0);
      s_rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         seen = seen | s_if_rsp_valid | s_ls_rsp_valid | s_ram_en;
      end
      check_eq("l3_no_rsp", 32'(seen), 32'd0);
      s_if_valid = 1'b1;
      #1 check_eq("l3_ready2", 32'(s_if_ready), 32'd1);
      @(posedge clk); #1 s_if_valid = 1'b0;
      x_en_k = 0; x_rsp_k = 0; x_rsp_d = 32'd0;
      for (int k = 1; k <= 10 && x_rsp_k == 0; k++) begin
         @(negedge clk);
         if (s_ram_en) x_en_k = k;
         if (s_if_rsp_valid) begin
            x_rsp_k = k; x_rsp_d = s_if_rsp_data;
         end
      end
      $display("xact l3_rd    en@%0d rsp@%0d data=%08h", x_en_k, x_rsp_k, x_rsp_d);
      check_eq("l3_en_cyc",  32'(x_en_k), 32'd1);
      check_eq("l3_rsp_cyc", 32'(x_rsp_k), 32'd4);
      check_eq("l3_data",    x_rsp_d, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
